// File: rtl/msc_pkg.sv
// Shared opcodes, status codes, sequencer states and the decoded-CDB payload
// for the mass-storage transfer sequencer.
package msc_pkg;

  localparam logic [7:0] OP_READ10  = 8'h28;
  localparam logic [7:0] OP_WRITE10 = 8'h2A;

  localparam logic [7:0] CSW_GOOD  = 8'd0;
  localparam logic [7:0] CSW_FAIL  = 8'd1;
  localparam logic [7:0] CSW_PHASE = 8'd2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECODE   = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_XFER     = 3'd3,
    ST_COMPLETE = 3'd4
  } seq_state_t;

  // issue=1 means at least one sector must be requested; otherwise status applies
  typedef struct packed {
    logic [31:0] lba;
    logic [15:0] blocks;
    logic        write;
    logic        issue;
    logic [7:0]  status;
  } cdb_dec_t;

endpackage

// File: rtl/msc_cdb_decode.sv
// Combinational READ_10/WRITE_10 field extraction with opcode, direction,
// LUN, block-count and capacity checks.
module msc_cdb_decode
  import msc_pkg::*;
#(
  parameter int unsigned MAX_LUNS         = 4,
  parameter int unsigned MAX_SECTOR_COUNT = 128,
  parameter int unsigned LUN_BLOCKS       = 32'h0010_0000
) (
  input  logic [127:0] i_cdb,
  input  logic [2:0]   i_lun,
  input  logic         i_data_in,
  output cdb_dec_t     o_dec
);

  logic [7:0]  w_opcode;
  logic [31:0] w_lba;
  logic [15:0] w_blocks;
  logic [32:0] w_end;
  logic        w_range_bad;
  logic        w_unused_cdb;

  assign w_opcode = i_cdb[7:0];
  assign w_lba    = {i_cdb[23:16], i_cdb[31:24], i_cdb[39:32], i_cdb[47:40]};
  assign w_blocks = {i_cdb[63:56], i_cdb[71:64]};
  // Widened so LBA near 2^32 cannot wrap past the capacity check
  assign w_end    = {1'b0, w_lba} + 33'(w_blocks);
  assign w_unused_cdb = ^{i_cdb[127:72], i_cdb[55:48], i_cdb[15:8]};

  assign w_range_bad = (32'(i_lun) >= MAX_LUNS) ||
                       (32'(w_blocks) > MAX_SECTOR_COUNT) ||
                       (w_end > 33'(LUN_BLOCKS));

  always_comb begin
    o_dec        = '0;
    o_dec.lba    = w_lba;
    o_dec.blocks = w_blocks;
    o_dec.write  = (w_opcode == OP_WRITE10);
    o_dec.status = CSW_GOOD;
    if (w_opcode != OP_READ10 && w_opcode != OP_WRITE10) begin
      o_dec.status = CSW_FAIL;
    end else if ((w_opcode == OP_READ10) != i_data_in) begin
      o_dec.status = CSW_PHASE;
    end else if (w_range_bad) begin
      o_dec.status = CSW_FAIL;
    end else if (w_blocks != 16'd0) begin
      o_dec.issue = 1'b1;
    end
  end

endmodule

// File: rtl/msc_xfer_sequencer.sv
// Splits SCSI READ_10/WRITE_10 commands into single-sector backend requests.
// Optional sector watchdog enabled by defining MSC_SEQ_TIMEOUT_EN.
module msc_xfer_sequencer
  import msc_pkg::*;
#(
  parameter int unsigned MAX_LUNS         = 4,
  parameter int unsigned MAX_SECTOR_COUNT = 128,
  parameter int unsigned SECTOR_SIZE      = 512,
  parameter int unsigned LUN_BLOCKS       = 32'h0010_0000,
  parameter int unsigned TIMEOUT_CYCLES   = 1_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] scsi_cdb,
  input  logic [2:0]   scsi_lun,
  input  logic         scsi_data_in,
  input  logic         scsi_valid,
  output logic         scsi_ready,
  output logic         scsi_done,
  output logic [7:0]   scsi_status,
  output logic         sec_req_valid,
  input  logic         sec_req_ready,
  output logic [31:0]  sec_req_lba,
  output logic [2:0]   sec_req_lun,
  output logic         sec_req_write,
  input  logic         sec_done,
  input  logic         sec_error,
  input  logic         data_beat,
  output logic         busy
);

  localparam int unsigned BEATS  = SECTOR_SIZE / 4;
  localparam int unsigned BEAT_W = $clog2(BEATS + 1);

  seq_state_t r_state, w_state_next;
  logic [127:0]      r_cdb, w_cdb_next;
  logic [2:0]        r_lun, w_lun_next;
  logic              r_data_in, w_data_in_next;
  logic [31:0]       r_lba, w_lba_next;
  logic [15:0]       r_remaining, w_remaining_next;
  logic              r_write, w_write_next;
  logic [BEAT_W-1:0] r_beat_cnt, w_beat_next, w_beat_inc;
  logic [7:0]        r_status, w_status_next;
  logic              r_scsi_ready, r_scsi_done, r_sec_req_valid, r_busy;
  logic              w_timeout;
  cdb_dec_t          w_dec;

  msc_cdb_decode #(
    .MAX_LUNS        (MAX_LUNS),
    .MAX_SECTOR_COUNT(MAX_SECTOR_COUNT),
    .LUN_BLOCKS      (LUN_BLOCKS)
  ) u_decode (
    .i_cdb    (r_cdb),
    .i_lun    (r_lun),
    .i_data_in(r_data_in),
    .o_dec    (w_dec)
  );

`ifdef MSC_SEQ_TIMEOUT_EN
  logic [31:0] r_wdog;
  logic        w_wdog_run;

  assign w_wdog_run = (r_state == ST_ISSUE && !sec_req_ready) || (r_state == ST_XFER);
  assign w_timeout  = (r_state == ST_ISSUE || r_state == ST_XFER) &&
                      (r_wdog >= TIMEOUT_CYCLES - 32'd1);

  // Restarts on every sector handshake and whenever no sector is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (w_wdog_run) begin
      r_wdog <= r_wdog + 32'd1;
    end else begin
      r_wdog <= '0;
    end
  end
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  // Beats past a full sector are dropped while waiting for sec_done
  assign w_beat_inc = r_beat_cnt +
                      BEAT_W'(data_beat && (r_beat_cnt != BEAT_W'(BEATS)));

  always_comb begin
    w_state_next     = r_state;
    w_cdb_next       = r_cdb;
    w_lun_next       = r_lun;
    w_data_in_next   = r_data_in;
    w_lba_next       = r_lba;
    w_remaining_next = r_remaining;
    w_write_next     = r_write;
    w_beat_next      = r_beat_cnt;
    w_status_next    = r_status;
    unique case (r_state)
      ST_IDLE: begin
        if (scsi_valid && r_scsi_ready) begin
          w_cdb_next     = scsi_cdb;
          w_lun_next     = scsi_lun;
          w_data_in_next = scsi_data_in;
          w_state_next   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_lba_next       = w_dec.lba;
        w_remaining_next = w_dec.blocks;
        w_write_next     = w_dec.write;
        w_beat_next      = '0;
        if (w_dec.issue) begin
          w_state_next = ST_ISSUE;
        end else begin
          w_status_next = w_dec.status;
          w_state_next  = ST_COMPLETE;
        end
      end
      ST_ISSUE: begin
        if (sec_req_ready) begin
          w_beat_next  = '0;
          w_state_next = ST_XFER;
        end
      end
      ST_XFER: begin
        w_beat_next = w_beat_inc;
        if (sec_done) begin
          if (w_beat_inc != BEAT_W'(BEATS)) begin
            w_status_next = CSW_PHASE;
            w_state_next  = ST_COMPLETE;
          end else if (sec_error) begin
            w_status_next = CSW_FAIL;
            w_state_next  = ST_COMPLETE;
          end else begin
            w_lba_next       = r_lba + 32'd1;
            w_remaining_next = r_remaining - 16'd1;
            if (r_remaining == 16'd1) begin
              w_status_next = CSW_GOOD;
              w_state_next  = ST_COMPLETE;
            end else begin
              w_state_next = ST_ISSUE;
            end
          end
        end
      end
      ST_COMPLETE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if (w_timeout) begin
      w_status_next = CSW_PHASE;
      w_state_next  = ST_COMPLETE;
    end
  end

  // Outputs are registered from the next state so they align with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_cdb           <= '0;
      r_lun           <= '0;
      r_data_in       <= 1'b0;
      r_lba           <= '0;
      r_remaining     <= '0;
      r_write         <= 1'b0;
      r_beat_cnt      <= '0;
      r_status        <= '0;
      r_scsi_ready    <= 1'b0;
      r_scsi_done     <= 1'b0;
      r_sec_req_valid <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_cdb           <= w_cdb_next;
      r_lun           <= w_lun_next;
      r_data_in       <= w_data_in_next;
      r_lba           <= w_lba_next;
      r_remaining     <= w_remaining_next;
      r_write         <= w_write_next;
      r_beat_cnt      <= w_beat_next;
      r_status        <= w_status_next;
      r_scsi_ready    <= (w_state_next == ST_IDLE);
      r_scsi_done     <= (w_state_next == ST_COMPLETE);
      r_sec_req_valid <= (w_state_next == ST_ISSUE);
      r_busy          <= (w_state_next != ST_IDLE);
    end
  end

  assign scsi_ready    = r_scsi_ready;
  assign scsi_done     = r_scsi_done;
  assign scsi_status   = r_status;
  assign sec_req_valid = r_sec_req_valid;
  assign sec_req_lba   = r_lba;
  assign sec_req_lun   = r_lun;
  assign sec_req_write = r_write;
  assign busy          = r_busy;

endmodule

// File: doc/msc_xfer_sequencer.md
# msc_xfer_sequencer

Sits between the `msc_protocol` SCSI interface and the sector storage backend, and sequences READ_10/WRITE_10 commands. It decodes each CDB and range-checks it, then splits the transfer into single-sector requests issued one at a time. It counts data beats per sector and returns one completion pulse with a BBB status byte. Non-data and unsupported commands complete immediately, so the protocol handler never stalls.

## Interface
Parameters:
- `MAX_LUNS`, 4: LUNs served; LUN ≥ `MAX_LUNS` is rejected.
- `MAX_SECTOR_COUNT`, 128: largest block count accepted per command.
- `SECTOR_SIZE`, 512: bytes per sector; beats per sector = `SECTOR_SIZE`/4.
- `LUN_BLOCKS`, 32'h0010_0000: capacity per LUN in sectors.
- `TIMEOUT_CYCLES`, 1_000_000: sector watchdog limit (used only when `MSC_SEQ_TIMEOUT_EN` is defined).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `scsi_cdb` in 128: CDB; byte n is at [8n+7:8n].
- `scsi_lun` in 3: target LUN.
- `scsi_data_in` in 1: 1 = device-to-host.
- `scsi_valid` in 1: command offered.
- `scsi_ready` out 1: command accepted when `scsi_valid` and `scsi_ready` are both high.
- `scsi_done` out 1: one-cycle completion pulse.
- `scsi_status` out 8: 0 = good, 1 = failed, 2 = phase error; valid while `scsi_done` is high and held until the next command.
- `sec_req_valid` out 1 / `sec_req_ready` in 1: sector request handshake.
- `sec_req_lba` out 32, `sec_req_lun` out 3, `sec_req_write` out 1: request fields.
- `sec_done` in 1, `sec_error` in 1: backend sector completion pulse and its error flag.
- `data_beat` in 1: one 32-bit word moved in either direction this cycle.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Reset value of every output is 0. State returns to IDLE and all counters clear.
- IDLE: `scsi_ready` = 1. On handshake, register the CDB, LUN and direction, then go to DECODE.
- DECODE (1 cycle): opcode = byte0. LBA = {b2,b3,b4,b5}. Blocks = {b7,b8}.
  - Opcode other than 0x28/0x2A: go to COMPLETE with status 1.
  - Direction mismatch (0x28 requires `scsi_data_in` = 1; 0x2A requires 0): status 2.
  - LUN ≥ `MAX_LUNS`, or blocks > `MAX_SECTOR_COUNT`, or LBA + blocks > `LUN_BLOCKS`: status 1. The addition is 33-bit, so it must not wrap.
  - Blocks = 0: status 0, no sector requests.
  - Otherwise go to ISSUE.
- ISSUE: `sec_req_valid` = 1 with the current LBA, LUN and `sec_req_write` = (opcode == 0x2A). Fields are stable until `sec_req_ready`. On handshake, go to XFER.
- XFER: count `data_beat` up to beats per sector. A `sec_done` arriving before the count completes gives status 2. A `sec_done` with `sec_error` gives status 1. Both abort to COMPLETE.
- XFER with the full count reached: wait for `sec_done`. Then increment LBA and decrement the remaining count. Go to ISSUE if remaining ≠ 0, otherwise COMPLETE with status 0.
- Beats beyond the sector count are ignored while waiting for `sec_done`.
- COMPLETE (1 cycle): `scsi_done` = 1, `scsi_status` driven, then go to IDLE.
- Asserting `rst_n` low mid-command aborts immediately. No `scsi_done` is produced.

## Timing
- Handshake to DECODE: 1 cycle. DECODE to `sec_req_valid`: 1 cycle.
- Fast-fail path: `scsi_done` 2 cycles after the command handshake.
- `sec_done` (last sector) to `scsi_done`: 1 cycle.
- `sec_done` to next `sec_req_valid`: 1 cycle.
- `scsi_ready` is low from the cycle after acceptance until IDLE is re-entered.
- `data_beat` and `sec_done` in the same cycle: the beat is counted first, then completion is evaluated against the updated count.

## Configuration
- `MSC_SEQ_TIMEOUT_EN` defined: a watchdog counts cycles in ISSUE and XFER and restarts on each sector handshake. Reaching `TIMEOUT_CYCLES` forces COMPLETE with status 2.
- `MSC_SEQ_TIMEOUT_EN` undefined: no counter is synthesized, and the sequencer waits indefinitely.

## Structure
- `msc_pkg` holds:
  - opcode constants `OP_READ10`/`OP_WRITE10`;
  - status constants `CSW_GOOD`/`CSW_FAIL`/`CSW_PHASE`;
  - the state enum.
- Sub-module `msc_cdb_decode`: combinational field extraction plus range and direction checks, registered in DECODE.

## Test plan
- READ_10, LUN 0, LBA 0x10, blocks 2, `data_in` = 1, backend answers with 128 beats per sector → two requests (LBA 0x10 then 0x11, write = 0), one `scsi_done`, status 0.
- WRITE_10, LBA 0, blocks 0 → no `sec_req_valid`, `scsi_done` 2 cycles after handshake, status 0.
- TEST UNIT READY (opcode 0x00) → status 1 with no sector requests; READ_10 with `data_in` = 0 → status 2.
- READ_10 with LBA 0x000F_FFFF, blocks 2, `LUN_BLOCKS` = 0x10_0000 → status 1. LUN 5 → status 1.
- READ_10, blocks 1, `sec_done` after 100 beats → status 2. `sec_done` with `sec_error` after 128 beats → status 1.
- With `MSC_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 50, `sec_req_ready` held low → status 2 at cycle 50. Reset pulsed mid-XFER → all outputs 0, `scsi_ready` = 1 after release.
